// File: rtl/score_accumulator.sv
// Per-round score engine: latches player identity, accumulates hit/miss over a fixed window,
// then reports the final score to the score tracker. Define STREAK_BONUS_EN for the streak bonus.
module score_accumulator #(
  parameter int ROUND_CYCLES = 1024,
  parameter int HIT_PTS      = 5,
  parameter int MISS_PTS     = 2,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] player_id,
  input  logic       guest,
  input  logic       hit,
  input  logic       miss,
  input  logic       valid,
  output logic       score_req,
  output logic [2:0] PlayerID,
  output logic       isGuest,
  output logic [6:0] score,
  output logic       busy,
  output logic       round_done,
  output logic       ack_err
);

  localparam int TW = (ROUND_CYCLES > 2) ? $clog2(ROUND_CYCLES) : 1;
  localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(ROUND_CYCLES - 1);
  localparam logic [AW-1:0] ACK_LOAD   = AW'(ACK_TIMEOUT);

  typedef enum logic [2:0] {IDLE, PLAY, REPORT, WAIT_ACK, DONE} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [AW-1:0] ack_cnt;
  logic [7:0]    hit_sum;
  logic [7:0]    miss_diff;
  logic [6:0]    hit_score;
  logic [6:0]    miss_score;

`ifdef STREAK_BONUS_EN
  logic [1:0] streak;
`endif

  always_comb begin
    // NOTE: hit_sum takes its base value before the optional bonus so no path leaves it unassigned (no latch).
    hit_sum = {1'b0, score} + 8'(HIT_PTS);
`ifdef STREAK_BONUS_EN
    if (streak == 2'd3) hit_sum = hit_sum + 8'd1;
`endif
    miss_diff = {1'b0, score} - 8'(MISS_PTS);
  end

  // Both operands are at most 127, so bit 7 flags overflow past 127 or underflow below 0.
  assign hit_score  = hit_sum[7]   ? 7'd127 : hit_sum[6:0];
  assign miss_score = miss_diff[7] ? 7'd0   : miss_diff[6:0];

  // NOTE: every state and output register here uses non-blocking assignment so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      timer      <= '0;
      ack_cnt    <= '0;
      score_req  <= 1'b0;
      PlayerID   <= 3'd0;
      isGuest    <= 1'b0;
      score      <= 7'd0;
      busy       <= 1'b0;
      round_done <= 1'b0;
      ack_err    <= 1'b0;
`ifdef STREAK_BONUS_EN
      streak     <= 2'd0;
`endif
    end else begin
      round_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            PlayerID <= player_id;
            isGuest  <= guest;
            score    <= 7'd0;
            timer    <= TIMER_LOAD;
            ack_err  <= 1'b0;
            busy     <= 1'b1;
            state    <= PLAY;
`ifdef STREAK_BONUS_EN
            streak   <= 2'd0;
`endif
          end
        end

        PLAY: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer - TW'(1);
            if (hit && !miss) begin
              score <= hit_score;
`ifdef STREAK_BONUS_EN
              if (streak != 2'd3) streak <= streak + 2'd1;
`endif
            end else if (miss) begin
              // A simultaneous hit and miss cancel out but still break the streak.
              if (!hit) score <= miss_score;
`ifdef STREAK_BONUS_EN
              streak <= 2'd0;
`endif
            end
            if (timer == '0) state <= REPORT;
          end
        end

        REPORT: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            score_req <= 1'b1;
            ack_cnt   <= ACK_LOAD;
            state     <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          if (abort) begin
            score_req <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (valid) begin
            score_req  <= 1'b0;
            round_done <= 1'b1;
            state      <= DONE;
          end else if (ack_cnt <= AW'(1)) begin
            // Counter reaches zero this edge with no acknowledge: abandon the report.
            ack_cnt   <= '0;
            ack_err   <= 1'b1;
            score_req <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            ack_cnt <= ack_cnt - AW'(1);
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          score_req <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_accumulator.sv
// Self-checking bench for score_accumulator: directed and randomized rounds compared against a
// behavioural score model; a second instance with a longer window covers the upper clamp.
`timescale 1ns/1ps
module tb_score_accumulator;

  localparam int RC      = 16;
  localparam int HP      = 5;
  localparam int MP      = 2;
  localparam int AT      = 4;
  localparam int RC_LONG = 32;
`ifdef STREAK_BONUS_EN
  localparam int STREAK_EXP = 27;
`else
  localparam int STREAK_EXP = 25;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, guest, hit, miss, valid;
  logic [2:0] player_id;
  logic       score_req, isGuest, busy, round_done, ack_err;
  logic [2:0] PlayerID;
  logic [6:0] score;

  logic       c_start, c_hit;
  logic       c_score_req, c_isGuest, c_busy, c_round_done, c_ack_err;
  logic [2:0] c_PlayerID;
  logic [6:0] c_score;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_score;
  int run_len;
  bit ev_hit[RC];
  bit ev_miss[RC];

  score_accumulator #(.ROUND_CYCLES(RC), .HIT_PTS(HP), .MISS_PTS(MP), .ACK_TIMEOUT(AT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .player_id(player_id), .guest(guest),
    .hit(hit), .miss(miss), .valid(valid), .score_req(score_req), .PlayerID(PlayerID),
    .isGuest(isGuest), .score(score), .busy(busy), .round_done(round_done), .ack_err(ack_err)
  );

  score_accumulator #(.ROUND_CYCLES(RC_LONG), .HIT_PTS(HP), .MISS_PTS(MP), .ACK_TIMEOUT(AT)) dut_clamp (
    .clk(clk), .rst(rst), .start(c_start), .abort(1'b0), .player_id(3'd0), .guest(1'b0),
    .hit(c_hit), .miss(1'b0), .valid(1'b1), .score_req(c_score_req), .PlayerID(c_PlayerID),
    .isGuest(c_isGuest), .score(c_score), .busy(c_busy), .round_done(c_round_done), .ack_err(c_ack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference scoring: clamp to 0..127, bonus once a run of three sole hits precedes this hit.
  task automatic model_step(input bit h, input bit m);
    int add;
    if (h && !m) begin
      add = HP;
`ifdef STREAK_BONUS_EN
      if (run_len >= 3) add = HP + 1;
`endif
      exp_score = (exp_score + add > 127) ? 127 : exp_score + add;
      run_len++;
    end else if (m) begin
      if (!h) exp_score = (exp_score - MP < 0) ? 0 : exp_score - MP;
      run_len = 0;
    end
  endtask

  task automatic clear_ev();
    for (int k = 0; k < RC; k++) begin
      ev_hit[k]  = 1'b0;
      ev_miss[k] = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ":score_req"}, score_req, 0);
    check({tag, ":PlayerID"}, PlayerID, 0);
    check({tag, ":isGuest"}, isGuest, 0);
    check({tag, ":score"}, score, 0);
    check({tag, ":busy"}, busy, 0);
    check({tag, ":round_done"}, round_done, 0);
    check({tag, ":ack_err"}, ack_err, 0);
  endtask

  // Starts a round and plays the event table; returns sampled in REPORT (or after an abort).
  task automatic play_round(input logic [2:0] id, input bit g, input int abort_at, input string name);
    bit   aborted;
    logic seen;
    player_id = id; guest = g; start = 1'b1;
    hit = 1'b0; miss = 1'b0; valid = 1'b0; abort = 1'b0;
    tick();
    start = 1'b0; player_id = ~id; guest = ~g;
    exp_score = 0; run_len = 0; aborted = 1'b0;
    check({name, ":busy_on"}, busy, 1);
    check({name, ":score_clr"}, score, 0);
    check({name, ":ack_err_clr"}, ack_err, 0);
    for (int k = 0; k < RC && !aborted; k++) begin
      hit = ev_hit[k]; miss = ev_miss[k];
      abort = (k == abort_at);
      start = 1'($urandom_range(0, 1));
      tick();
      if (k == abort_at) aborted = 1'b1;
      else model_step(ev_hit[k], ev_miss[k]);
    end
    start = 1'b0; abort = 1'b0;
    hit = 1'($urandom); miss = 1'($urandom);
    if (aborted) begin
      check({name, ":abort_busy"}, busy, 0);
      check({name, ":abort_req"}, score_req, 0);
      check({name, ":abort_score"}, score, exp_score);
      seen = 1'b0;
      repeat (RC + 6) begin
        tick();
        seen = seen | score_req;
      end
      hit = 1'b0; miss = 1'b0;
      check({name, ":abort_req_never"}, seen, 0);
      check({name, ":abort_score_hold"}, score, exp_score);
    end else begin
      check({name, ":report_score"}, score, exp_score);
      check({name, ":report_req_low"}, score_req, 0);
      check({name, ":report_busy"}, busy, 1);
      check({name, ":PlayerID"}, PlayerID, id);
      check({name, ":isGuest"}, isGuest, g);
    end
  endtask

  // vdelay: cycles of score_req before valid is seen; values outside 1..AT never acknowledge in time.
  task automatic ack_phase(input int vdelay, input string name);
    bit ok;
    int req_len;
    tick();
    ok = (vdelay >= 1 && vdelay <= AT);
    req_len = ok ? vdelay : AT;
    for (int i = 0; i < req_len + 3; i++) begin
      check({name, ":req"}, score_req, (i < req_len) ? 1 : 0);
      check({name, ":round_done"}, round_done, (ok && i == vdelay) ? 1 : 0);
      check({name, ":busy"}, busy, (i < (ok ? vdelay + 1 : AT)) ? 1 : 0);
      check({name, ":ack_err"}, ack_err, (!ok && i >= AT) ? 1 : 0);
      check({name, ":score_hold"}, score, exp_score);
      valid = (i == vdelay - 1);
      hit = 1'($urandom); miss = 1'($urandom);
      tick();
    end
    valid = 1'b0; hit = 1'b0; miss = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; guest = 1'b0; hit = 1'b0; miss = 1'b0;
    valid = 1'b0; player_id = 3'd0; c_start = 1'b0; c_hit = 1'b0;
    #12;
    check_zero("reset");
    check("reset_c:score_req", c_score_req, 0);
    check("reset_c:PlayerID", c_PlayerID, 0);
    check("reset_c:isGuest", c_isGuest, 0);
    check("reset_c:score", c_score, 0);
    check("reset_c:busy", c_busy, 0);
    check("reset_c:round_done", c_round_done, 0);
    check("reset_c:ack_err", c_ack_err, 0);
    rst = 1'b1;
    tick();

    // Basic round: 4 hits then 1 miss, acknowledged after 2 cycles.
    clear_ev();
    for (int k = 0; k < 4; k++) ev_hit[k] = 1'b1;
    ev_miss[4] = 1'b1;
    play_round(3'd3, 1'b0, -1, "basic");
    check("basic:score18", score, 18);
    ack_phase(2, "basic");

    // Randomized rounds, including late and missing acknowledges.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < RC; k++) begin
        ev_hit[k]  = ($urandom_range(0, 9) < 5);
        ev_miss[k] = ($urandom_range(0, 9) < 3);
      end
      play_round(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, "rand");
      ack_phase(int'($urandom_range(1, 6)), "rand");
    end

    // Floor clamp on a fresh round.
    clear_ev();
    for (int k = 0; k < 3; k++) ev_miss[k] = 1'b1;
    play_round(3'd5, 1'b1, -1, "floor");
    check("floor:score0", score, 0);
    ack_phase(1, "floor");

    // Simultaneous hit and miss leaves the score alone.
    clear_ev();
    ev_hit[0] = 1'b1; ev_hit[1] = 1'b1; ev_hit[2] = 1'b1; ev_miss[2] = 1'b1;
    play_round(3'd1, 1'b0, -1, "both");
    check("both:score10", score, 10);
    ack_phase(AT, "both");

    // Timeout: no acknowledge; ack_err must clear on the next accepted start.
    clear_ev();
    ev_hit[7] = 1'b1;
    play_round(3'd6, 1'b1, -1, "timeout");
    ack_phase(-1, "timeout");

    // Abort after two hits.
    clear_ev();
    ev_hit[0] = 1'b1; ev_hit[1] = 1'b1; ev_hit[2] = 1'b1;
    play_round(3'd2, 1'b0, 2, "abort");
    check("abort:score10", score, 10);

    // Hit in the final play cycle is counted.
    clear_ev();
    ev_hit[RC-1] = 1'b1;
    play_round(3'd7, 1'b1, -1, "last");
    check("last:score5", score, 5);
    ack_phase(3, "last");

    // Five consecutive hits.
    clear_ev();
    for (int k = 0; k < 5; k++) ev_hit[k] = 1'b1;
    play_round(3'd4, 1'b0, -1, "streak");
    check("streak:score", score, STREAK_EXP);
    ack_phase(2, "streak");

    // Asynchronous reset while waiting for the acknowledge.
    clear_ev();
    ev_hit[0] = 1'b1; ev_hit[3] = 1'b1;
    play_round(3'd5, 1'b1, -1, "rstwait");
    tick();
    check("rstwait:req_high", score_req, 1);
    #2 rst = 1'b0;
    #1 check_zero("rstwait");
    #1 rst = 1'b1;
    tick();
    check_zero("rstwait_idle");

    // Upper clamp: 30 hits on the long-window instance.
    c_start = 1'b1;
    tick();
    c_start = 1'b0; c_hit = 1'b1;
    exp_score = 0; run_len = 0;
    repeat (30) begin
      tick();
      model_step(1'b1, 1'b0);
    end
    c_hit = 1'b0;
    check("clamp:score_model", c_score, exp_score);
    check("clamp:score127", c_score, 127);
    repeat (8) tick();
    check("clamp:busy_done", c_busy, 0);
    check("clamp:ack_err", c_ack_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
